// File: rtl/main_mem_pkg.sv
// Shared types and defaults for the main memory arbiter and the schedulers that reuse its picker.
package main_mem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int NREQ_DEF   = 4;
  localparam int AW_DEF     = 10;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_DEF = 1;
  localparam int GNT_W      = 3;
endpackage

// File: rtl/main_mem_arb_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr (mod N) wins.
// Zero latency; no backpressure of its own.
module rr_pick
  import main_mem_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic [N-1:0]     req_m,
  input  logic [GNT_W-1:0] ptr,
  output logic             any,
  output logic [GNT_W-1:0] idx
);

  logic [2*N-1:0] rot;

  always_comb begin
    int cand;
    cand = 0;
    any  = |req_m;
    idx  = '0;
    rot  = {req_m, req_m} >> ptr;
    // Scan from the far end so the closest requester after ptr is written last.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        cand = int'(ptr) + k;
        if (cand >= N) cand = cand - N;
        idx = GNT_W'(cand);
      end
    end
  end

endmodule

// File: rtl/main_mem_arb.sv
// Round-robin arbiter sharing one single-port memory; write service 3 cycles, read 3+RD_LAT.
// Requesters hold req until their one-cycle ack; requests are only sampled in IDLE.
module main_mem_arb
  import main_mem_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [GNT_W-1:0]     gnt_id,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  state_t           state;
  logic [GNT_W-1:0] rr_ptr;
  logic             mask_vld;
  logic [1:0]       wait_cnt;
  logic [NREQ-1:0]  req_m;
  logic             pick_any;
  logic [GNT_W-1:0] pick_idx;
  logic [GNT_W-1:0] next_ptr;

  assign req_m    = req & ~(mask_vld ? (NREQ'(1) << gnt_id) : '0);
  assign next_ptr = (gnt_id == GNT_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  rr_pick #(.N(NREQ)) u_pick (
    .req_m (req_m),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      mask_vld  <= 1'b0;
      wait_cnt  <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      gnt_id    <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack    <= '0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          mask_vld <= 1'b0;
          if (pick_any) begin
            gnt_id    <= pick_idx;
            mem_cs    <= 1'b1;
            mem_we    <= we[int'(pick_idx)];
            mem_addr  <= addr[int'(pick_idx)*AW +: AW];
            mem_wdata <= wdata[int'(pick_idx)*DW +: DW];
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // mem_we still carries the latched write flag during GRANT.
          if (mem_we) begin
            ack   <= NREQ'(1) << gnt_id;
            state <= ACK;
          end else begin
            // A latency of 4 wraps to 0 and counts 0,3,2,1: still four WAIT cycles.
            wait_cnt <= 2'(RD_LAT);
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd1) begin
            rdata <= mem_rdata;
            ack   <= NREQ'(1) << gnt_id;
            state <= ACK;
          end
        end
        ACK: begin
          rr_ptr   <= next_ptr;
          mask_vld <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arb.sv
// Scoreboard bench for main_mem_arb: RD_LAT=1 main instance plus RD_LAT=2 and RD_LAT=4 read-latency instances.
module tb_main_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req, we;
  logic [39:0] addr;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic        busy, mem_cs, mem_we;
  logic [2:0]  gnt_id;
  logic [9:0]  mem_addr;

  logic [3:0]  req2_s, req4_s;
  logic [3:0]  we_s = '0;
  logic [39:0] addr_s;
  logic [63:0] wdata_s = '0;
  logic [3:0]  ack2, ack4;
  logic [15:0] rdata2, rdata4, mwd2, mwd4, mrd2, mrd4;
  logic        busy2, busy4, cs2, cs4, mwe2, mwe4;
  logic [2:0]  gnt2, gnt4;
  logic [9:0]  maddr2, maddr4;

  main_mem_arb #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .gnt_id(gnt_id), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  main_mem_arb #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset), .req(req2_s), .we(we_s), .addr(addr_s), .wdata(wdata_s),
    .ack(ack2), .rdata(rdata2), .busy(busy2), .gnt_id(gnt2), .mem_cs(cs2),
    .mem_we(mwe2), .mem_addr(maddr2), .mem_wdata(mwd2), .mem_rdata(mrd2));

  main_mem_arb #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(4)) dut_lat4 (
    .clk(clk), .reset(reset), .req(req4_s), .we(we_s), .addr(addr_s), .wdata(wdata_s),
    .ack(ack4), .rdata(rdata4), .busy(busy4), .gnt_id(gnt4), .mem_cs(cs4),
    .mem_we(mwe4), .mem_addr(maddr4), .mem_wdata(mwd4), .mem_rdata(mrd4));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] memfn(logic [9:0] a);
    return {a[5:0], a} ^ 16'h3C5A;
  endfunction

  // Main memory: writable array, read data valid only in the single cycle RD_LAT after mem_cs.
  logic [15:0] mem [1024];
  logic        rv1 = 1'b0;
  logic [15:0] rd1;
  always @(posedge clk) begin
    rv1 <= mem_cs & ~mem_we;
    if (mem_cs & ~mem_we) rd1 <= mem[mem_addr];
    if (mem_cs & mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = rv1 ? rd1 : 16'hBAD0;

  // Read-only memories for the latency instances, data derived from the address.
  logic [1:0]  v2 = '0;
  logic [3:0]  v4 = '0;
  logic [15:0] d2 [2];
  logic [15:0] d4 [4];
  always @(posedge clk) begin
    v2 <= {v2[0], cs2 & ~mwe2};
    d2[0] <= memfn(maddr2);
    d2[1] <= d2[0];
    v4 <= {v4[2:0], cs4 & ~mwe4};
    d4[0] <= memfn(maddr4);
    for (int k = 1; k < 4; k++) d4[k] <= d4[k-1];
  end
  assign mrd2 = v2[1] ? d2[1] : 16'hBAD0;
  assign mrd4 = v4[3] ? d4[3] : 16'hBAD0;

  typedef struct {
    int          dut;
    logic [3:0]  ack;
    int          gid;
    int          cyc;
    bit          chk_rd;
    logic [15:0] rdata;
  } ack_exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
  } cs_exp_t;

  ack_exp_t ack_q[$];
  cs_exp_t  cs_q[$];
  ack_exp_t ea;
  cs_exp_t  ec;

  int checks = 0;
  int errors = 0;

  int         remaining [4];
  int         pend_drop [4];
  logic [3:0] pend_raise, hold1;

  function automatic void exp_ack(int d, int id, int c, bit rd, logic [15:0] v);
    ack_exp_t e;
    e.dut = d; e.ack = 4'b0001 << id; e.gid = id; e.cyc = c; e.chk_rd = rd; e.rdata = v;
    ack_q.push_back(e);
  endfunction

  function automatic void exp_cs(int c, logic w, logic [9:0] a, logic [15:0] v);
    cs_exp_t e;
    e.cyc = c; e.we = w; e.addr = a; e.wdata = v;
    cs_q.push_back(e);
  endfunction

  // Requester behaviour: drop on ack, optionally hold one extra cycle or re-raise for another turn.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pend_raise[i]) begin req[i] = 1'b1; pend_raise[i] = 1'b0; end
      if (pend_drop[i] > 0) begin
        pend_drop[i]--;
        if (pend_drop[i] == 0) req[i] = 1'b0;
      end
      if (ack[i]) begin
        if (hold1[i]) pend_drop[i] = 2; else req[i] = 1'b0;
        if (remaining[i] > 1) pend_raise[i] = 1'b1;
        if (remaining[i] > 0) remaining[i]--;
      end
    end
    req2_s = req2_s & ~ack2;
    req4_s = req4_s & ~ack4;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ack_q.size() != 0 || cs_q.size() != 0) && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (ack_q.size() != 0 || cs_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d acks and %0d mem_cs still outstanding, required 0", ack_q.size(), cs_q.size());
      ack_q.delete();
      cs_q.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    req2_s = '0; req4_s = '0; addr_s = '0;
    pend_raise = '0; hold1 = '0;
    for (int i = 0; i < 4; i++) begin remaining[i] = 0; pend_drop[i] = 0; end
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          for (int d = 0; d < 3; d++) begin
            logic [3:0]  a;
            logic [15:0] rd;
            logic [2:0]  g;
            a  = (d == 0) ? ack : (d == 1) ? ack2 : ack4;
            rd = (d == 0) ? rdata : (d == 1) ? rdata2 : rdata4;
            g  = (d == 0) ? gnt_id : (d == 1) ? gnt2 : gnt4;
            if (a != 4'b0000) begin
              checks++;
              if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: dut%0d ack=%b at cycle %0d, required none", d, a, cyc);
              end else begin
                ea = ack_q.pop_front();
                if (ea.dut != d || a !== ea.ack || int'(g) != ea.gid || cyc != ea.cyc ||
                    (ea.chk_rd && rd !== ea.rdata)) begin
                  errors++;
                  $display("FAIL ack_event: got dut%0d ack=%b gnt=%0d cyc=%0d rdata=%h, required dut%0d ack=%b gnt=%0d cyc=%0d rdata=%h",
                           d, a, g, cyc, rd, ea.dut, ea.ack, ea.gid, ea.cyc, ea.rdata);
                end
              end
            end
          end
          if (mem_cs) begin
            checks++;
            if (cs_q.size() == 0) begin
              errors++;
              $display("FAIL cs_unexpected: mem_cs at cycle %0d addr=%h, required none", cyc, mem_addr);
            end else begin
              ec = cs_q.pop_front();
              if (cyc != ec.cyc || mem_we !== ec.we || mem_addr !== ec.addr || mem_wdata !== ec.wdata) begin
                errors++;
                $display("FAIL cs_event: got cyc=%0d we=%b addr=%h wdata=%h, required cyc=%0d we=%b addr=%h wdata=%h",
                         cyc, mem_we, mem_addr, mem_wdata, ec.cyc, ec.we, ec.addr, ec.wdata);
              end
            end
          end
        end
      end
      begin : stimulus
        int s;
        repeat (3) tick();
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // All four requesters write at once out of reset; requester 0 comes back for a second turn.
        tick(); s = cyc;
        reset = 1'b0; req = 4'b1111; we = 4'b1111;
        for (int i = 0; i < 4; i++) begin
          addr[i*10 +: 10]  = 10'(256 + i);
          wdata[i*16 +: 16] = 16'(49152 + i);
          remaining[i] = (i == 0) ? 2 : 1;
        end
        for (int k = 0; k < 5; k++) begin
          int id;
          id = (k == 4) ? 0 : k;
          exp_cs(s + 1 + 3*k, 1'b1, 10'(256 + id), 16'(49152 + id));
          exp_ack(0, id, s + 2 + 3*k, 1'b0, 16'h0);
        end
        drain();

        // Requester 2: write 0xA5C3 to 0x015, then read it back.
        tick(); s = cyc;
        req[2] = 1'b1; we[2] = 1'b1; addr[20 +: 10] = 10'h015; wdata[32 +: 16] = 16'hA5C3;
        remaining[2] = 1;
        exp_cs(s + 1, 1'b1, 10'h015, 16'hA5C3);
        exp_ack(0, 2, s + 2, 1'b0, 16'h0);
        drain();
        tick(); s = cyc;
        req[2] = 1'b1; we[2] = 1'b0; remaining[2] = 1;
        exp_cs(s + 1, 1'b0, 10'h015, 16'hA5C3);
        exp_ack(0, 2, s + 3, 1'b1, 16'hA5C3);
        drain();

        // Fairness from rr_ptr=3: requesters 0 and 3 keep coming back.
        tick(); s = cyc;
        req[0] = 1'b1; req[3] = 1'b1; we[0] = 1'b1; we[3] = 1'b1;
        addr[0 +: 10] = 10'h200; addr[30 +: 10] = 10'h203;
        wdata[0 +: 16] = 16'h0A00; wdata[48 +: 16] = 16'h3A03;
        remaining[0] = 2; remaining[3] = 2;
        exp_cs(s + 1, 1'b1, 10'h203, 16'h3A03);  exp_ack(0, 3, s + 2, 1'b0, 16'h0);
        exp_cs(s + 4, 1'b1, 10'h200, 16'h0A00);  exp_ack(0, 0, s + 5, 1'b0, 16'h0);
        exp_cs(s + 7, 1'b1, 10'h203, 16'h3A03);  exp_ack(0, 3, s + 8, 1'b0, 16'h0);
        exp_cs(s + 10, 1'b1, 10'h200, 16'h0A00); exp_ack(0, 0, s + 11, 1'b0, 16'h0);
        drain();
        chk("rdata_hold_after_writes", rdata, 16'hA5C3);

        // Requester 1 keeps req high through the first IDLE cycle after its ack.
        tick(); s = cyc;
        req[1] = 1'b1; we[1] = 1'b1; addr[10 +: 10] = 10'h111; wdata[16 +: 16] = 16'h1111;
        remaining[1] = 1; hold1[1] = 1'b1;
        exp_cs(s + 1, 1'b1, 10'h111, 16'h1111);
        exp_ack(0, 1, s + 2, 1'b0, 16'h0);
        repeat (4) tick();
        chk("mask_req_held", {31'b0, cyc == s + 4}, 1);
        chk("mask_mem_cs", mem_cs, 0);
        chk("mask_busy", busy, 0);
        hold1[1] = 1'b0;
        drain();

        // Reset while the read of requester 2 sits in WAIT.
        tick(); s = cyc;
        req[2] = 1'b1; we[2] = 1'b0; remaining[2] = 1;
        exp_cs(s + 1, 1'b0, 10'h015, 16'hA5C3);
        tick();
        tick();
        reset = 1'b1; req[2] = 1'b0; remaining[2] = 0;
        tick();
        chk("midrst_ack", ack, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_cs", mem_cs, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_gnt_id", gnt_id, 0);
        reset = 1'b0; s = cyc;
        req[0] = 1'b1; req[3] = 1'b1; remaining[0] = 1; remaining[3] = 1;
        exp_cs(s + 1, 1'b1, 10'h200, 16'h0A00); exp_ack(0, 0, s + 2, 1'b0, 16'h0);
        exp_cs(s + 4, 1'b1, 10'h203, 16'h3A03); exp_ack(0, 3, s + 5, 1'b0, 16'h0);
        drain();

        // Read latency 2 and 4: ack at T+4 and T+6.
        tick(); s = cyc;
        addr_s[10 +: 10] = 10'h033; req2_s[1] = 1'b1; req4_s[1] = 1'b1;
        exp_ack(1, 1, s + 4, 1'b1, memfn(10'h033));
        exp_ack(2, 1, s + 6, 1'b1, memfn(10'h033));
        drain();
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_mem_arb.md
# main_mem_arb

Round-robin arbiter and sequencer that shares the single-port main memory (`main_mem`) between up to four requesters, for example the ADPCM channel datapath, the serial TDM interface and the configuration port. It accepts one request per requester over a req/ack handshake and drives a single memory transaction at a time with registered outputs. Read data returns through a shared data bus, qualified by a per-requester ack pulse.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `AW`, default 10: memory address width.
- `DW`, default 16: memory data width.
- `RD_LAT`, default 1: memory read latency in cycles from `mem_cs` to valid `mem_rdata`, 1..4.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester transaction request; held high until the matching `ack`.
- `we`  in  NREQ  per-requester write enable (1 = write, 0 = read); stable while `req` is high.
- `addr`  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- `wdata`  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester.
- `rdata`  out  DW  registered read data; valid in the cycle where a read's `ack` is high.
- `busy`  out  1  high while a transaction is in progress (any state other than IDLE).
- `gnt_id`  out  3  index of the current or last granted requester.
- `mem_cs`  out  1  memory select, one-cycle pulse per transaction.
- `mem_we`  out  1  memory write strobe, qualified by `mem_cs`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data.

## Operation
- FSM states are IDLE, GRANT, WAIT and ACK.
- **IDLE**
  - If any unmasked `req` is high, select a winner by round-robin priority starting at `rr_ptr`.
  - Latch the winner's index, `we`, `addr` and `wdata`, then go to GRANT.
  - If no unmasked request is pending, stay in IDLE.
- **GRANT**
  - `mem_cs` = 1; `mem_we`, `mem_addr` and `mem_wdata` come from the latched values.
  - For a write, go to ACK.
  - For a read, load the wait counter with RD_LAT and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1, capture `mem_rdata` into `rdata` and go to ACK.
- **ACK**
  - `ack[gnt_id]` = 1 for exactly one cycle.
  - `rr_ptr` becomes (`gnt_id`+1) mod NREQ.
  - Go to IDLE.
- **Post-ACK mask**
  - In the first IDLE cycle after ACK, `req[gnt_id]` is ignored, so requesters with registered logic can drop `req`.
  - From the second IDLE cycle onward, the mask is cleared.
- **Simultaneous requests:** the lowest index at or after `rr_ptr` (modulo NREQ) wins. No requester waits more than NREQ-1 transactions.
- **Request changes while not in IDLE:** they have no effect. Requests are sampled only in IDLE, and the latched operands are used throughout the transaction.
- **Deasserted `req`:** if a requester drops `req` before its `ack`, the transaction still completes and the `ack` is still issued. This case is a protocol violation and is not flagged.
- **Memory outputs outside GRANT:** `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last values.
- **`rdata`** holds its value until the next read capture. A write does not change it.
- **Reset**
  - Values: state = IDLE, `rr_ptr` = 0, mask cleared, `ack` = 0, `mem_cs` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rdata` = 0, `busy` = 0, `gnt_id` = 0.
  - Reset mid-transaction abandons the transaction with no `ack`. A `mem_cs` already issued for a write is not undone.

## Timing
- The first `req` is seen in IDLE at cycle T.
- Write: `mem_cs` is high at T+1 and `ack` is high at T+2. Service time is 3 cycles.
- Read: `mem_cs` is high at T+1 and `mem_rdata` is sampled at T+1+RD_LAT. `ack` and `rdata` are valid at T+2+RD_LAT. Service time is 3+RD_LAT cycles.
- Back-to-back transactions from different requesters: the next `mem_cs` follows 2 cycles after the previous `ack` (ACK → IDLE → GRANT).
- All outputs are registered; there is no combinational path from `req` to `ack` or to any `mem_*` output.

## Structure
- Package `main_mem_pkg`:
  - state enum (IDLE, GRANT, WAIT, ACK, 2-bit encoding);
  - defaults for `NREQ`, `AW`, `DW` and `RD_LAT`;
  - `GNT_W` = 3.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: masked request vector and `rr_ptr`.
  - Outputs: `any` and winner index.
  - It is reused by the later channel scheduler.
- Wait counter: 2 bits wide.

## Test plan
- **Single write then read:** requester 2 writes 0xA5C3 to address 0x015, then reads 0x015 with RD_LAT=1.
  - Required: the write `ack[2]` arrives 2 cycles after `req` is first seen.
  - Required: the read `ack[2]` arrives 3 cycles after `req` is seen, with `rdata` = 0xA5C3.
- **All requesters at once:** `req` = 4'b1111 from reset.
  - Required: grant order 0, 1, 2, 3, then 0.
  - Required: each `ack` arrives once, with `mem_cs` pulses 3 cycles apart for writes.
- **Fairness:** requesters 0 and 3 hold `req` continuously and drop it only for the cycle after their `ack`.
  - Required: grants alternate 3, 0, 3, 0 after `rr_ptr` = 3.
- **Post-ACK mask:** requester 1 holds `req` one cycle after `ack[1]`.
  - Required: no second grant to requester 1.
  - Required: `mem_cs` stays 0 in that cycle.
- **Read latency sweep:** RD_LAT = 1, 2 and 4.
  - Required: `ack` arrives at T+3, T+4 and T+6 respectively.
  - Required: `rdata` equals the memory model's value captured at T+1+RD_LAT.
- **Reset mid-read:** assert `reset` during WAIT.
  - Required: no `ack` is issued.
  - Required: the next cycle shows all outputs at reset values, `busy` = 0, and the next grant goes to requester 0.
